// File: rtl/fp_addsub_param.sv
// fp_addsub_param: six-clock parametrised floating-point adder/subtractor (IDLE..DONE FSM).
// Build macro FP_ADDSUB_RNE_EN selects round-to-nearest-even; undefined gives truncation.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 15,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] inst_a,
  input  logic [W-1:0] inst_b,
  input  logic         op_sel,
  input  logic         enable,
  output logic [W-1:0] result,
  output logic [7:0]   status,
  output logic         done_flag,
  output logic         busy
);

  localparam int XW = MAN_W + 4;
  localparam int SW = XW + 1;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(XW);
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(MAN_W + 3);
  localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] EXP_ZERO = {EW{1'b0}};
  localparam logic signed [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_UNPACK = 3'd1, S_ALIGN = 3'd2, S_ADD = 3'd3,
    S_NORM = 3'd4, S_ROUND = 3'd5, S_DONE = 3'd6
  } state_t;

  state_t state_r, state_next_s;
  logic accept_s, done_next_s, busy_next_s;
  logic done_r, busy_r;
  logic [W-1:0] result_r, res_s;
  logic [7:0] status_r, stat_s;

  logic [W-1:0] a_r, b_r;
  logic op_r;
  logic [EXP_W-1:0] a_exp_s, b_exp_s;
  logic a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s, b_sign_eff_s;
  logic [W-2:0] a_mag_s, b_mag_s;
  logic [MAN_W:0] a_man_s, b_man_s;
  logic big_sign_s, small_sign_s, nan_s, inf_s, inf_sign_s;
  logic [EXP_W-1:0] big_exp_s, small_exp_s;
  logic [MAN_W:0] big_man_s, small_man_s;

  logic big_sign_r, small_sign_r, nan_r, inf_r, inf_sign_r;
  logic [EXP_W-1:0] big_exp_r, small_exp_r;
  logic [MAN_W:0] big_man_r, small_man_r;

  logic [EXP_W-1:0] diff_s;
  logic [XW-1:0] small_ext_s, lost_s, aligned_s, aligned_r;
  logic [SW-1:0] big_ext_s, small_add_s, sum_s, sum_r;
  logic [LW-1:0] lz_s;
  logic signed [EW-1:0] exp_ext_s, nexp_s, nexp_r, rexp_s;
  logic [XW-1:0] norm_s, norm_r;
  logic zero_s, zero_r;
  logic inexact_s, inc_s;
  logic [MAN_W+1:0] rounded_s;
  logic [MAN_W-1:0] rfrac_s;

  function automatic logic [LW-1:0] lead_zeros(input logic [XW-1:0] v);
    logic [LW-1:0] n;
    n = {LW{1'b0}};
    for (int i = 0; i < XW; i++) begin
      if (v[i]) n = LW'(XW - 1 - i);
    end
    return n;
  endfunction

  // State register plus registered handshake and result outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      result_r <= {W{1'b0}};
      status_r <= 8'h00;
    end else begin
      state_r <= state_next_s;
      done_r  <= done_next_s;
      busy_r  <= busy_next_s;
      if (state_r == S_ROUND) begin
        result_r <= res_s;
        status_r <= stat_s;
      end
    end
  end

  // Next-state logic; DONE may accept a new operation directly
  always_comb begin
    state_next_s = S_IDLE;
    case (state_r)
      S_IDLE:   state_next_s = enable ? S_UNPACK : S_IDLE;
      S_UNPACK: state_next_s = S_ALIGN;
      S_ALIGN:  state_next_s = S_ADD;
      S_ADD:    state_next_s = S_NORM;
      S_NORM:   state_next_s = S_ROUND;
      S_ROUND:  state_next_s = S_DONE;
      S_DONE:   state_next_s = enable ? S_UNPACK : S_IDLE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // Output decode feeding the registered handshake
  always_comb begin
    accept_s    = ((state_r == S_IDLE) || (state_r == S_DONE)) && enable;
    done_next_s = (state_next_s == S_DONE);
    busy_next_s = (state_next_s != S_IDLE);
  end

  // Unpack: flush exp==0 to zero, classify specials, order operands by magnitude
  always_comb begin
    a_exp_s      = a_r[W-2:MAN_W];
    b_exp_s      = b_r[W-2:MAN_W];
    a_zero_s     = (a_exp_s == {EXP_W{1'b0}});
    b_zero_s     = (b_exp_s == {EXP_W{1'b0}});
    a_inf_s      = (a_exp_s == EXP_ONES) && (a_r[MAN_W-1:0] == {MAN_W{1'b0}});
    b_inf_s      = (b_exp_s == EXP_ONES) && (b_r[MAN_W-1:0] == {MAN_W{1'b0}});
    a_nan_s      = (a_exp_s == EXP_ONES) && (a_r[MAN_W-1:0] != {MAN_W{1'b0}});
    b_nan_s      = (b_exp_s == EXP_ONES) && (b_r[MAN_W-1:0] != {MAN_W{1'b0}});
    b_sign_eff_s = b_r[W-1] ^ op_r;
    a_mag_s      = a_zero_s ? {(W-1){1'b0}} : a_r[W-2:0];
    b_mag_s      = b_zero_s ? {(W-1){1'b0}} : b_r[W-2:0];
    a_man_s      = a_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, a_r[MAN_W-1:0]};
    b_man_s      = b_zero_s ? {(MAN_W+1){1'b0}} : {1'b1, b_r[MAN_W-1:0]};
    if (b_mag_s > a_mag_s) begin
      big_sign_s = b_sign_eff_s; big_exp_s = b_mag_s[W-2:MAN_W]; big_man_s = b_man_s;
      small_sign_s = a_r[W-1]; small_exp_s = a_mag_s[W-2:MAN_W]; small_man_s = a_man_s;
    end else begin
      big_sign_s = a_r[W-1]; big_exp_s = a_mag_s[W-2:MAN_W]; big_man_s = a_man_s;
      small_sign_s = b_sign_eff_s; small_exp_s = b_mag_s[W-2:MAN_W]; small_man_s = b_man_s;
    end
    nan_s      = a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (a_r[W-1] != b_sign_eff_s));
    inf_s      = a_inf_s || b_inf_s;
    inf_sign_s = a_inf_s ? a_r[W-1] : b_sign_eff_s;
  end

  // Align and add: large shifts collapse the smaller operand into the sticky bit
  always_comb begin
    diff_s      = big_exp_r - small_exp_r;
    small_ext_s = {small_man_r, 3'b000};
    lost_s      = small_ext_s & ~({XW{1'b1}} << diff_s);
    if (diff_s >= SHIFT_MAX) begin
      aligned_s = {{(XW-1){1'b0}}, |small_man_r};
    end else begin
      aligned_s = (small_ext_s >> diff_s) | {{(XW-1){1'b0}}, |lost_s};
    end
    big_ext_s   = {1'b0, big_man_r, 3'b000};
    small_add_s = {1'b0, aligned_r};
    if (big_sign_r != small_sign_r) begin
      sum_s = big_ext_s - small_add_s;
    end else begin
      sum_s = big_ext_s + small_add_s;
    end
  end

  // Normalise: carry-out shifts right keeping sticky, else leading-one left shift
  always_comb begin
    lz_s      = lead_zeros(sum_r[XW-1:0]);
    exp_ext_s = {2'b00, big_exp_r};
    if (sum_r[XW]) begin
      norm_s = {sum_r[XW:2], sum_r[1] | sum_r[0]};
      nexp_s = exp_ext_s + EXP_ONE;
      zero_s = 1'b0;
    end else if (sum_r == {SW{1'b0}}) begin
      norm_s = {XW{1'b0}};
      nexp_s = EXP_ZERO;
      zero_s = 1'b1;
    end else begin
      norm_s = sum_r[XW-1:0] << lz_s;
      nexp_s = exp_ext_s - {{(EW-LW){1'b0}}, lz_s};
      zero_s = 1'b0;
    end
  end

  // Round, renormalise on fraction carry, then resolve specials and range limits
  always_comb begin
    inexact_s = |norm_r[2:0];
`ifdef FP_ADDSUB_RNE_EN
    inc_s = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
`else
    inc_s = 1'b0;
`endif
    rounded_s = {1'b0, norm_r[XW-1:3]} + {{(MAN_W+1){1'b0}}, inc_s};
    if (rounded_s[MAN_W+1]) begin
      rexp_s  = nexp_r + EXP_ONE;
      rfrac_s = rounded_s[MAN_W:1];
    end else begin
      rexp_s  = nexp_r;
      rfrac_s = rounded_s[MAN_W-1:0];
    end
    if (nan_r) begin
      res_s = QNAN;                                          stat_s = 8'h10;
    end else if (inf_r) begin
      res_s = {inf_sign_r, EXP_ONES, {MAN_W{1'b0}}};         stat_s = 8'h00;
    end else if (zero_r) begin
      res_s = {W{1'b0}};                                     stat_s = 8'h01;
    end else if (rexp_s >= EXP_MAX) begin
      res_s = {big_sign_r, EXP_ONES, {MAN_W{1'b0}}};         stat_s = 8'h0A;
    end else if (rexp_s <= EXP_ZERO) begin
      res_s = {W{1'b0}};                                     stat_s = 8'h0C;
    end else begin
      res_s  = {big_sign_r, rexp_s[EXP_W-1:0], rfrac_s};
      stat_s = {4'b0000, inexact_s, 3'b000};
    end
  end

  // Datapath stage registers, each loaded only in its own state
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_r <= {W{1'b0}}; b_r <= {W{1'b0}}; op_r <= 1'b0;
      big_sign_r <= 1'b0; small_sign_r <= 1'b0; nan_r <= 1'b0; inf_r <= 1'b0; inf_sign_r <= 1'b0;
      big_exp_r <= {EXP_W{1'b0}}; small_exp_r <= {EXP_W{1'b0}};
      big_man_r <= {(MAN_W+1){1'b0}}; small_man_r <= {(MAN_W+1){1'b0}};
      aligned_r <= {XW{1'b0}}; sum_r <= {SW{1'b0}};
      norm_r <= {XW{1'b0}}; nexp_r <= EXP_ZERO; zero_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            a_r <= inst_a; b_r <= inst_b; op_r <= op_sel;
          end
        end
        S_UNPACK: begin
          big_sign_r <= big_sign_s; small_sign_r <= small_sign_s;
          big_exp_r <= big_exp_s; small_exp_r <= small_exp_s;
          big_man_r <= big_man_s; small_man_r <= small_man_s;
          nan_r <= nan_s; inf_r <= inf_s; inf_sign_r <= inf_sign_s;
        end
        S_ALIGN: aligned_r <= aligned_s;
        S_ADD:   sum_r <= sum_s;
        S_NORM: begin
          norm_r <= norm_s; nexp_r <= nexp_s; zero_r <= zero_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign result    = result_r;
  assign status    = status_r;
  assign done_flag = done_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_fp_addsub_param.sv
// Directed bench for fp_addsub_param (default widths); expectations follow FP_ADDSUB_RNE_EN.
module tb_fp_addsub_param;

  logic        clock;
  logic        reset;
  logic [23:0] inst_a, inst_b;
  logic        op_sel, enable;
  logic [23:0] result;
  logic [7:0]  status;
  logic        done_flag, busy;

  int checks = 0;
  int errors = 0;

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [23:0] EXP_ROUND     = 24'h3F8001;
  localparam logic [23:0] EXP_RND_CARRY = 24'h400000;
  localparam logic [23:0] EXP_SUB_STKY  = 24'h3F8000;
`else
  localparam logic [23:0] EXP_ROUND     = 24'h3F8000;
  localparam logic [23:0] EXP_RND_CARRY = 24'h3FFFFF;
  localparam logic [23:0] EXP_SUB_STKY  = 24'h3F7FFF;
`endif

  fp_addsub_param dut (
    .clock     (clock),
    .reset     (reset),
    .inst_a    (inst_a),
    .inst_b    (inst_b),
    .op_sel    (op_sel),
    .enable    (enable),
    .result    (result),
    .status    (status),
    .done_flag (done_flag),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation: accept, scramble inputs, wait (bounded) for done, check everything.
  task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                        input logic op, input logic [23:0] er, input logic [7:0] es);
    int n;
    @(negedge clock);
    inst_a = a; inst_b = b; op_sel = op; enable = 1'b1;
    @(posedge clock);
    n = 1;
    @(negedge clock);
    enable = 1'b0;
    inst_a = 24'($urandom); inst_b = 24'($urandom); op_sel = 1'($urandom_range(0, 1));
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (done_flag !== 1'b1 && n < 20) begin
      @(posedge clock); n++; @(negedge clock);
    end
    check({tag, "_latency"}, 32'(n), 32'd6);
    check({tag, "_done"}, 32'(done_flag), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_status"}, 32'(status), 32'(es));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(posedge clock); @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done_flag), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_result_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    int n;
    int dones;
    reset = 1'b0; enable = 1'b0; inst_a = 24'h000000; inst_b = 24'h000000; op_sel = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_result", 32'(result), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_done", 32'(done_flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    run_op("add_1p1",   24'h3F8000, 24'h3F8000, 1'b0, 24'h400000, 8'h00);
    run_op("sub_2m3",   24'h400000, 24'h404000, 1'b1, 24'hBF8000, 8'h00);
    run_op("cancel",    24'h3F8000, 24'h3F8000, 1'b1, 24'h000000, 8'h01);
    run_op("overflow",  24'h7F7FFF, 24'h7F7FFF, 1'b0, 24'h7F8000, 8'h0A);
    run_op("inf_m_inf", 24'h7F8000, 24'h7F8000, 1'b1, 24'h7FC000, 8'h10);
    run_op("round",     24'h3F8000, 24'h37C000, 1'b0, EXP_ROUND, 8'h08);
    run_op("sticky",    24'h3F8000, 24'h308000, 1'b0, 24'h3F8000, 8'h08);
    run_op("underflow", 24'h00C000, 24'h008000, 1'b1, 24'h000000, 8'h0C);
    run_op("denorm",    24'h3F8000, 24'h000001, 1'b0, 24'h3F8000, 8'h00);
    run_op("nan_in",    24'h7F8001, 24'h3F8000, 1'b0, 24'h7FC000, 8'h10);
    run_op("neg_inf",   24'hFF8000, 24'h3F8000, 1'b0, 24'hFF8000, 8'h00);
    run_op("rnd_carry", 24'h3FFFFF, 24'h37C000, 1'b0, EXP_RND_CARRY, 8'h08);
    run_op("sub_stky",  24'h3F8000, 24'h308000, 1'b1, EXP_SUB_STKY, 8'h08);

    // Reset asserted while the op sits in ADD: everything clears, no done follows.
    @(negedge clock);
    inst_a = 24'h3F8000; inst_b = 24'h3F8000; op_sel = 1'b0; enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_status", 32'(status), 32'd0);
    check("midrst_done", 32'(done_flag), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    dones = 0;
    repeat (12) begin
      @(posedge clock); @(negedge clock);
      if (done_flag === 1'b1) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op("post_rst", 24'h3F8000, 24'h3F8000, 1'b0, 24'h400000, 8'h00);

    // Enable held high through the busy window yields one done; dropped in DONE.
    @(negedge clock);
    inst_a = 24'h400000; inst_b = 24'h3F8000; op_sel = 1'b0; enable = 1'b1;
    n = 0;
    while (done_flag !== 1'b1 && n < 20) begin
      @(posedge clock); n++; @(negedge clock);
    end
    check("hold_latency", 32'(n), 32'd6);
    check("hold_result", 32'(result), 32'h00404000);
    enable = 1'b0;
    dones = 0;
    repeat (15) begin
      @(posedge clock); @(negedge clock);
      if (done_flag === 1'b1) dones++;
    end
    check("hold_single_done", 32'(dones), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
